// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants for the hazard controller.
package cpu_pkg;

    localparam int unsigned REG_W            = 5;
    localparam int unsigned DRAIN_CNT_W      = 2;
    localparam int unsigned IRQ_DRAIN_CYCLES = 2;
    localparam logic [REG_W-1:0] REG_ZERO    = 5'd0;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        FETCH_WAIT   = 2'd1,
        IRQ_DRAIN    = 2'd2,
        IRQ_REDIRECT = 2'd3
    } hazard_state_e;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_sel_irq;
        logic irq_ack;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_RUN      = hazard_ctrl_t'(6'b110000);
    localparam hazard_ctrl_t CTRL_BUBBLE   = hazard_ctrl_t'(6'b001000);
    localparam hazard_ctrl_t CTRL_REDIRECT = hazard_ctrl_t'(6'b101011);
    localparam hazard_ctrl_t CTRL_RESET    = hazard_ctrl_t'(6'b001100);

    // Steady-state RUN controls: branch beats load-use beats jump.
    function automatic hazard_ctrl_t run_ctrl(
        input logic load_use,
        input logic branch_taken,
        input logic jump
    );
        hazard_ctrl_t c;
        c = CTRL_RUN;
        if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_wr       = 1'b0;
            c.if_id_wr    = 1'b0;
            c.id_ex_flush = 1'b1;
        end else if (jump) begin
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the IF/ID sources and the ID/EX load target.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    output logic             o_load_use
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign o_load_use = i_ex_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/interrupt-redirect controller; outputs are same-cycle enables.
// Optional HAZARD_CTRL_STATS_EN adds a saturating stall-cycle counter output.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             imem_ready,
    input  logic             irq,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_sel_irq,
    output logic             irq_ack
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    hazard_state_e          r_state;
    hazard_state_e          w_state_nxt;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic [DRAIN_CNT_W-1:0] w_drain_cnt_nxt;
    logic                   r_pend_redirect;
    logic                   w_pend_redirect_nxt;
    logic                   r_irq_armed;
    logic                   w_irq_armed_nxt;
    logic                   w_load_use;
    logic                   w_irq_accept;
    hazard_ctrl_t           w_ctrl;

    hazard_detect u_hazard_detect (
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rt  (id_uses_rt),
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rt       (ex_rt),
        .o_load_use    (w_load_use)
    );

    // A taken branch holds off the interrupt; level irq retries next cycle.
    assign w_irq_accept = irq && r_irq_armed && !ex_branch_taken;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= RUN;
            r_drain_cnt     <= '0;
            r_pend_redirect <= 1'b0;
            r_irq_armed     <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            r_drain_cnt     <= w_drain_cnt_nxt;
            r_pend_redirect <= w_pend_redirect_nxt;
            r_irq_armed     <= w_irq_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_drain_cnt_nxt     = r_drain_cnt;
        w_pend_redirect_nxt = r_pend_redirect;
        w_irq_armed_nxt     = r_irq_armed || !irq;
        w_ctrl              = CTRL_RUN;

        case (r_state)
            RUN: begin
                if (!imem_ready) begin
                    // Fetch miss: bubble, but a branch still kills ID/EX and is remembered.
                    w_ctrl              = CTRL_BUBBLE;
                    w_ctrl.id_ex_flush  = ex_branch_taken;
                    w_pend_redirect_nxt = ex_branch_taken;
                    w_state_nxt         = FETCH_WAIT;
                end else begin
                    w_ctrl = run_ctrl(w_load_use, ex_branch_taken, id_jump);
                end
                if (w_irq_accept) begin
                    w_state_nxt         = IRQ_DRAIN;
                    w_drain_cnt_nxt     = '0;
                    w_pend_redirect_nxt = 1'b0;
                end
            end
            FETCH_WAIT: begin
                if (imem_ready) begin
                    w_ctrl = run_ctrl(w_load_use, ex_branch_taken, id_jump);
                    if (r_pend_redirect) begin
                        w_ctrl.pc_wr = 1'b1;
                    end
                    w_pend_redirect_nxt = 1'b0;
                    w_state_nxt         = RUN;
                end else begin
                    w_ctrl             = CTRL_BUBBLE;
                    w_ctrl.id_ex_flush = ex_branch_taken;
                    if (ex_branch_taken) begin
                        w_pend_redirect_nxt = 1'b1;
                    end
                end
            end
            IRQ_DRAIN: begin
                w_ctrl = CTRL_BUBBLE;
                if (r_drain_cnt == DRAIN_CNT_W'(IRQ_DRAIN_CYCLES - 1)) begin
                    w_drain_cnt_nxt = '0;
                    w_state_nxt     = IRQ_REDIRECT;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DRAIN_CNT_W'(1);
                end
            end
            IRQ_REDIRECT: begin
                w_ctrl          = CTRL_REDIRECT;
                w_irq_armed_nxt = 1'b0;
                w_state_nxt     = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase

        if (!reset) begin
            w_ctrl = CTRL_RESET;
        end
    end

    assign pc_wr       = w_ctrl.pc_wr;
    assign if_id_wr    = w_ctrl.if_id_wr;
    assign if_id_flush = w_ctrl.if_id_flush;
    assign id_ex_flush = w_ctrl.id_ex_flush;
    assign pc_sel_irq  = w_ctrl.pc_sel_irq;
    assign irq_ack     = w_ctrl.irq_ack;

`ifdef HAZARD_CTRL_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!w_ctrl.pc_wr && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
